// File: rtl/glitch_pkg.sv
// Shared types and defaults for the glitch monitor.
//   state_t        measurement FSM states
//   CNT_W_DEFAULT  default width of the delay/width counters
package glitch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE,
    REPORT
  } state_t;

  localparam int unsigned CNT_W_DEFAULT = 32;

endpackage

// File: rtl/glitch_monitor_sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous input plus
// single-cycle rise/fall detection on the synchronized value.
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (all flops to 0)
//   d     in   asynchronous input
//   q     out  d after SYNC_STAGES flops
//   rise  out  q went 0->1 this cycle
//   fall  out  q went 1->0 this cycle
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // minimum 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   q_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      q_d    <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      q_d    <= sync_r[SYNC_STAGES-1];
    end
  end

  assign q    = sync_r[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/glitch_monitor.sv
// glitch_monitor: drives the glitch generator trigger, then measures the
// trigger-to-glitch delay and the glitch pulse width in clk cycles, with a
// timeout. The result is offered on a valid/ready handshake.
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   start          in   run a measurement (honoured only in IDLE)
//   trigger_out    out  generator trigger, high while waiting for the rise
//   glitch_in      in   returned glitch line, asynchronous
//   busy           out  high in every state except IDLE
//   result_valid   out  result available, held until accepted
//   result_ready   in   consumer accepts the result
//   delay_count    out  cycles from trigger to detected rise (includes sync latency)
//   width_count    out  cycles the synchronized glitch stayed high
//   timeout        out  result is an abort
//   done_indicator out  LED, mirrors result_valid
module glitch_monitor
  import glitch_pkg::*;
#(
  parameter int unsigned     CNT_W         = CNT_W_DEFAULT,
  parameter longint unsigned TIMEOUT_COUNT = 600_000_000,  // must be <= 2**CNT_W-1
  parameter int unsigned     SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             trigger_out,
  input  logic             glitch_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] delay_count,
  output logic [CNT_W-1:0] width_count,
  output logic             timeout,
  output logic             done_indicator
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_COUNT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] dcnt, wcnt;
  logic             glitch_s, rise, fall;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (glitch_in),
    .q   (glitch_s),
    .rise(rise),
    .fall(fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (rise)                  state_next = MEASURE;
        else if (dcnt == TMO_LAST) state_next = REPORT;
      end
      MEASURE:   if (fall || wcnt == TMO_LAST) state_next = REPORT;
      REPORT:    if (result_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The cycle in which the rise is detected is already the first high
  // cycle of the synchronized glitch, so wcnt is loaded with 1 there; that
  // makes width_count equal the exact number of high cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt        <= '0;
      wcnt        <= '0;
      delay_count <= '0;
      width_count <= '0;
      timeout     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dcnt        <= '0;
            wcnt        <= '0;
            delay_count <= '0;
            width_count <= '0;
            timeout     <= 1'b0;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            delay_count <= dcnt;
            wcnt        <= CNT_W'(1);
          end else begin
            dcnt <= (dcnt == '1) ? dcnt : dcnt + CNT_W'(1);
            if (dcnt == TMO_LAST) timeout <= 1'b1;
          end
        end
        MEASURE: begin
          if (fall) begin
            width_count <= wcnt;
          end else begin
            if (glitch_s) wcnt <= (wcnt == '1) ? wcnt : wcnt + CNT_W'(1);
            if (wcnt == TMO_LAST) begin
              timeout     <= 1'b1;
              width_count <= wcnt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign trigger_out    = (state == WAIT_RISE);
  assign busy           = (state != IDLE);
  assign result_valid   = (state == REPORT);
  assign done_indicator = result_valid;

endmodule

// File: tb/tb_glitch_monitor.sv
module tb_glitch_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: default timeout
  logic        a_start = 1'b0, a_glitch = 1'b0, a_ready = 1'b0;
  logic        a_trig, a_busy, a_valid, a_tmo, a_done;
  logic [31:0] a_delay, a_width;

  // Instance B: TIMEOUT_COUNT = 50
  logic        b_start = 1'b0, b_glitch = 1'b0, b_ready = 1'b0;
  logic        b_trig, b_busy, b_valid, b_tmo, b_done;
  logic [31:0] b_delay, b_width;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  glitch_monitor dut_a (
    .clk(clk), .rst(rst), .start(a_start), .trigger_out(a_trig),
    .glitch_in(a_glitch), .busy(a_busy), .result_valid(a_valid),
    .result_ready(a_ready), .delay_count(a_delay), .width_count(a_width),
    .timeout(a_tmo), .done_indicator(a_done)
  );

  glitch_monitor #(.TIMEOUT_COUNT(50)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .trigger_out(b_trig),
    .glitch_in(b_glitch), .busy(b_busy), .result_valid(b_valid),
    .result_ready(b_ready), .delay_count(b_delay), .width_count(b_width),
    .timeout(b_tmo), .done_indicator(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (a_valid === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_b_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (b_valid === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if ({a_trig, a_busy, a_valid, a_tmo, a_done} !== 5'b0) begin errors++; $display("FAIL reset_a_flags: got %b expected 00000", {a_trig, a_busy, a_valid, a_tmo, a_done}); end
    checks++; if ({a_delay, a_width} !== 64'd0) begin errors++; $display("FAIL reset_a_counts: got %0d/%0d expected 0/0", a_delay, a_width); end
    checks++; if ({b_trig, b_busy, b_valid, b_tmo, b_done} !== 5'b0) begin errors++; $display("FAIL reset_b_flags: got %b expected 00000", {b_trig, b_busy, b_valid, b_tmo, b_done}); end
    rst = 1'b0;
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL after_reset_busy: got %b expected 0", a_busy); end
  endtask

  task automatic test_measure();
    bit ok;
    a_start = 1'b1; tick(); a_start = 1'b0;
    checks++; if (a_trig !== 1'b1) begin errors++; $display("FAIL measure_trigger: got %b expected 1", a_trig); end
    repeat (100) tick();
    a_glitch = 1'b1;
    repeat (30) tick();
    a_glitch = 1'b0;
    wait_a_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL measure_valid: got no result_valid expected result within 20 cycles"); end
    checks++; if (a_delay !== 32'd102) begin errors++; $display("FAIL measure_delay: got %0d expected 102", a_delay); end
    checks++; if (a_width !== 32'd30) begin errors++; $display("FAIL measure_width: got %0d expected 30", a_width); end
    checks++; if ({a_tmo, a_trig, a_done} !== 3'b001) begin errors++; $display("FAIL measure_flags: got tmo/trig/done %b expected 001", {a_tmo, a_trig, a_done}); end
    a_ready = 1'b1; tick(); a_ready = 1'b0;
    checks++; if ({a_valid, a_busy} !== 2'b00) begin errors++; $display("FAIL measure_ack: got valid/busy %b expected 00", {a_valid, a_busy}); end
  endtask

  task automatic test_timeout_wait();
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (49) tick();
    checks++; if ({b_trig, b_valid} !== 2'b10) begin errors++; $display("FAIL tmo_before: got trig/valid %b expected 10", {b_trig, b_valid}); end
    tick();
    checks++; if ({b_valid, b_tmo, b_trig} !== 3'b110) begin errors++; $display("FAIL tmo_wait: got valid/tmo/trig %b expected 110", {b_valid, b_tmo, b_trig}); end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL tmo_ack_busy: got %b expected 0", b_busy); end
  endtask

  task automatic test_high_before_start();
    bit ok;
    a_glitch = 1'b1;
    repeat (4) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (10) tick();
    a_glitch = 1'b0;
    repeat (10) tick();
    a_glitch = 1'b1;
    repeat (5) tick();
    a_glitch = 1'b0;
    wait_a_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hbs_valid: got no result_valid expected result within 20 cycles"); end
    checks++; if ({a_delay, a_width} !== {32'd22, 32'd5}) begin errors++; $display("FAIL hbs_counts: got %0d/%0d expected 22/5", a_delay, a_width); end
    checks++; if (a_tmo !== 1'b0) begin errors++; $display("FAIL hbs_timeout: got %b expected 0", a_tmo); end
    a_ready = 1'b1; tick(); a_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (4) tick();
    a_glitch = 1'b1;
    repeat (3) tick();
    a_glitch = 1'b0;
    wait_a_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_valid: got no result_valid expected result within 20 cycles"); end
    for (int i = 0; i < 7; i++) begin
      a_start = (i == 3);
      tick();
      a_start = 1'b0;
      checks++; if ({a_valid, a_tmo, a_delay, a_width} !== {1'b1, 1'b0, 32'd6, 32'd3}) begin errors++; $display("FAIL hold_cycle%0d: got valid=%b tmo=%b %0d/%0d expected valid=1 tmo=0 6/3", i, a_valid, a_tmo, a_delay, a_width); end
    end
    a_ready = 1'b1; tick(); a_ready = 1'b0;
    checks++; if ({a_valid, a_busy, a_trig} !== 3'b000) begin errors++; $display("FAIL hold_ack: got valid/busy/trig %b expected 000", {a_valid, a_busy, a_trig}); end
    a_ready = 1'b1; tick(); a_ready = 1'b0;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL stray_ready: got busy %b expected 0", a_busy); end
    a_start = 1'b1; tick(); a_start = 1'b0;
    checks++; if ({a_trig, a_busy} !== 2'b11) begin errors++; $display("FAIL restart: got trig/busy %b expected 11", {a_trig, a_busy}); end
  endtask

  task automatic test_short_and_long();
    bit ok;
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (5) tick();
    b_glitch = 1'b1; tick(); b_glitch = 1'b0;
    wait_b_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_valid: got no result_valid expected result within 20 cycles"); end
    checks++; if ({b_delay, b_width, b_tmo} !== {32'd7, 32'd1, 1'b0}) begin errors++; $display("FAIL short_result: got %0d/%0d tmo=%b expected 7/1 tmo=0", b_delay, b_width, b_tmo); end
    b_ready = 1'b1; tick(); b_ready = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (3) tick();
    b_glitch = 1'b1;
    wait_b_valid(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL long_valid: got no result_valid expected result within 100 cycles"); end
    checks++; if ({b_delay, b_width, b_tmo} !== {32'd5, 32'd49, 1'b1}) begin errors++; $display("FAIL long_result: got %0d/%0d tmo=%b expected 5/49 tmo=1", b_delay, b_width, b_tmo); end
    b_glitch = 1'b0;
    b_ready = 1'b1; tick(); b_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    // dut_a is still waiting for a rise from test_back_to_back
    checks++; if (a_trig !== 1'b1) begin errors++; $display("FAIL mid_pre_trig: got %b expected 1", a_trig); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_trig, a_busy} !== 2'b00) begin errors++; $display("FAIL mid_reset: got trig/busy %b expected 00", {a_trig, a_busy}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({a_busy, a_valid, a_delay} !== {1'b0, 1'b0, 32'd0}) begin errors++; $display("FAIL mid_idle: got busy=%b valid=%b delay=%0d expected 0 0 0", a_busy, a_valid, a_delay); end
  endtask

  initial begin
    test_reset();
    test_measure();
    test_timeout_wait();
    test_high_before_start();
    test_back_to_back();
    test_short_and_long();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
